// File: rtl/cc_mem_arbiter_if.sv
// Bus bundle for cc_mem_arbiter: CPU request port, loader/debug port and main-memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface cc_mem_arbiter_if #(
    parameter int DATAWIDTH_ADDR = 32,
    parameter int DATAWIDTH_DATA = 32
);
    logic                      Mem_Arbiter_CPU_RD;
    logic                      Mem_Arbiter_CPU_WR;
    logic [DATAWIDTH_ADDR-1:0] Mem_Arbiter_CPU_ADDR;
    logic [DATAWIDTH_DATA-1:0] Mem_Arbiter_CPU_WDATA;
    logic [DATAWIDTH_DATA-1:0] Mem_Arbiter_CPU_RDATA;
    logic                      Mem_Arbiter_CPU_ACK;

    logic                      Mem_Arbiter_LD_REQ;
    logic                      Mem_Arbiter_LD_WE;
    logic [DATAWIDTH_ADDR-1:0] Mem_Arbiter_LD_ADDR;
    logic [DATAWIDTH_DATA-1:0] Mem_Arbiter_LD_WDATA;
    logic [DATAWIDTH_DATA-1:0] Mem_Arbiter_LD_RDATA;
    logic                      Mem_Arbiter_LD_ACK;

    logic                      Mem_Arbiter_MEM_RD;
    logic                      Mem_Arbiter_MEM_WR;
    logic [DATAWIDTH_ADDR-1:0] Mem_Arbiter_MEM_ADDR;
    logic [DATAWIDTH_DATA-1:0] Mem_Arbiter_MEM_WDATA;
    logic [DATAWIDTH_DATA-1:0] Mem_Arbiter_MEM_RDATA;
    logic                      Mem_Arbiter_MEM_ACK;

    logic                      Mem_Arbiter_BUSY;
    logic                      Mem_Arbiter_ERR;
    logic                      Mem_Arbiter_ERR_CLEAR_InLow;

    modport slave (
        input  Mem_Arbiter_CPU_RD, Mem_Arbiter_CPU_WR, Mem_Arbiter_CPU_ADDR, Mem_Arbiter_CPU_WDATA,
        output Mem_Arbiter_CPU_RDATA, Mem_Arbiter_CPU_ACK,
        input  Mem_Arbiter_LD_REQ, Mem_Arbiter_LD_WE, Mem_Arbiter_LD_ADDR, Mem_Arbiter_LD_WDATA,
        output Mem_Arbiter_LD_RDATA, Mem_Arbiter_LD_ACK,
        output Mem_Arbiter_MEM_RD, Mem_Arbiter_MEM_WR, Mem_Arbiter_MEM_ADDR, Mem_Arbiter_MEM_WDATA,
        input  Mem_Arbiter_MEM_RDATA, Mem_Arbiter_MEM_ACK,
        output Mem_Arbiter_BUSY, Mem_Arbiter_ERR,
        input  Mem_Arbiter_ERR_CLEAR_InLow
    );

    modport master (
        output Mem_Arbiter_CPU_RD, Mem_Arbiter_CPU_WR, Mem_Arbiter_CPU_ADDR, Mem_Arbiter_CPU_WDATA,
        input  Mem_Arbiter_CPU_RDATA, Mem_Arbiter_CPU_ACK,
        output Mem_Arbiter_LD_REQ, Mem_Arbiter_LD_WE, Mem_Arbiter_LD_ADDR, Mem_Arbiter_LD_WDATA,
        input  Mem_Arbiter_LD_RDATA, Mem_Arbiter_LD_ACK,
        input  Mem_Arbiter_MEM_RD, Mem_Arbiter_MEM_WR, Mem_Arbiter_MEM_ADDR, Mem_Arbiter_MEM_WDATA,
        output Mem_Arbiter_MEM_RDATA, Mem_Arbiter_MEM_ACK,
        input  Mem_Arbiter_BUSY, Mem_Arbiter_ERR,
        output Mem_Arbiter_ERR_CLEAR_InLow
    );
endinterface

// File: rtl/cc_mem_arbiter.sv
// Two-port main-memory arbiter (CPU microcode path vs. loader/debug port), all outputs registered.
// Optional access watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module cc_mem_arbiter #(
    parameter int DATAWIDTH_ADDR    = 32,
    parameter int DATAWIDTH_DATA    = 32,
    parameter int TIMEOUT_CYCLES    = 255,
    parameter int DATAWIDTH_TIMEOUT = 8
) (
    input  logic            Mem_Arbiter_CLOCK_50,
    input  logic            Mem_Arbiter_RESET_InLow,
    cc_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LD  = 1'b1;

    state_t                    state_r;
    state_t                    state_s;
    logic                      owner_r;
    logic                      owner_s;
    logic                      we_r;
    logic                      we_s;
    logic                      last_ld_r;
    logic                      last_ld_s;
    logic [DATAWIDTH_ADDR-1:0] mem_addr_r;
    logic [DATAWIDTH_ADDR-1:0] mem_addr_s;
    logic [DATAWIDTH_DATA-1:0] mem_wdata_r;
    logic [DATAWIDTH_DATA-1:0] mem_wdata_s;
    logic                      mem_rd_r;
    logic                      mem_rd_s;
    logic                      mem_wr_r;
    logic                      mem_wr_s;
    logic                      cpu_ack_r;
    logic                      cpu_ack_s;
    logic                      ld_ack_r;
    logic                      ld_ack_s;
    logic [DATAWIDTH_DATA-1:0] cpu_rdata_r;
    logic [DATAWIDTH_DATA-1:0] cpu_rdata_s;
    logic [DATAWIDTH_DATA-1:0] ld_rdata_r;
    logic [DATAWIDTH_DATA-1:0] ld_rdata_s;
    logic                      busy_r;
    logic                      busy_s;
    logic                      err_r;
    logic                      err_s;

    logic                      cpu_req_s;
    logic                      owner_req_s;
    logic                      grant_ld_s;
    logic                      grant_we_s;
    logic                      expire_s;
    logic                      err_clear_s;

    assign cpu_req_s   = bus.Mem_Arbiter_CPU_RD | bus.Mem_Arbiter_CPU_WR;
    assign owner_req_s = (owner_r == OWNER_LD) ? bus.Mem_Arbiter_LD_REQ : cpu_req_s;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam logic [DATAWIDTH_TIMEOUT-1:0] TIMEOUT_LAST =
        DATAWIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [DATAWIDTH_TIMEOUT-1:0] wd_cnt_r;
    logic [DATAWIDTH_TIMEOUT-1:0] wd_cnt_s;

    // Watchdog: counts ACK-less ACCESS cycles; held at zero outside ACCESS so entry starts clean.
    always_comb begin
        wd_cnt_s = {DATAWIDTH_TIMEOUT{1'b0}};
        expire_s = 1'b0;
        if ((state_r == ST_ACCESS) && !bus.Mem_Arbiter_MEM_ACK) begin
            expire_s = (wd_cnt_r == TIMEOUT_LAST);
            wd_cnt_s = wd_cnt_r + {{(DATAWIDTH_TIMEOUT-1){1'b0}}, 1'b1};
        end else begin
            wd_cnt_s = {DATAWIDTH_TIMEOUT{1'b0}};
        end
    end

    // Watchdog counter register.
    always_ff @(posedge Mem_Arbiter_CLOCK_50 or negedge Mem_Arbiter_RESET_InLow) begin
        if (!Mem_Arbiter_RESET_InLow) begin
            wd_cnt_r <= {DATAWIDTH_TIMEOUT{1'b0}};
        end else begin
            wd_cnt_r <= wd_cnt_s;
        end
    end

    assign err_clear_s = ~bus.Mem_Arbiter_ERR_CLEAR_InLow;
`else
    logic unused_cfg_s;

    assign expire_s     = 1'b0;
    assign err_clear_s  = 1'b0;
    assign unused_cfg_s = bus.Mem_Arbiter_ERR_CLEAR_InLow
                        ^ (TIMEOUT_CYCLES != 0)
                        ^ (DATAWIDTH_TIMEOUT != 0);
`endif

    // Next-state and next-output logic; every output register is computed here.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        we_s        = we_r;
        last_ld_s   = last_ld_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_rd_s    = mem_rd_r;
        mem_wr_s    = mem_wr_r;
        cpu_ack_s   = cpu_ack_r;
        ld_ack_s    = ld_ack_r;
        cpu_rdata_s = cpu_rdata_r;
        ld_rdata_s  = ld_rdata_r;
        busy_s      = busy_r;
        err_s       = err_r;
        grant_ld_s  = 1'b0;
        grant_we_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (cpu_req_s || bus.Mem_Arbiter_LD_REQ) begin
                    // On a tie the side not served last wins; CPU wins right after reset.
                    grant_ld_s = bus.Mem_Arbiter_LD_REQ && (!cpu_req_s || !last_ld_r);
                    if (grant_ld_s) begin
                        grant_we_s  = bus.Mem_Arbiter_LD_WE;
                        owner_s     = OWNER_LD;
                        mem_addr_s  = bus.Mem_Arbiter_LD_ADDR;
                        mem_wdata_s = bus.Mem_Arbiter_LD_WDATA;
                    end else begin
                        grant_we_s  = bus.Mem_Arbiter_CPU_WR;
                        owner_s     = OWNER_CPU;
                        mem_addr_s  = bus.Mem_Arbiter_CPU_ADDR;
                        mem_wdata_s = bus.Mem_Arbiter_CPU_WDATA;
                    end
                    we_s     = grant_we_s;
                    mem_rd_s = ~grant_we_s;
                    mem_wr_s = grant_we_s;
                    busy_s   = 1'b1;
                    state_s  = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                if (bus.Mem_Arbiter_MEM_ACK) begin
                    mem_rd_s  = 1'b0;
                    mem_wr_s  = 1'b0;
                    last_ld_s = owner_r;
                    state_s   = ST_DONE;
                    if (owner_r == OWNER_LD) begin
                        ld_ack_s   = 1'b1;
                        ld_rdata_s = we_r ? ld_rdata_r : bus.Mem_Arbiter_MEM_RDATA;
                    end else begin
                        cpu_ack_s   = 1'b1;
                        cpu_rdata_s = we_r ? cpu_rdata_r : bus.Mem_Arbiter_MEM_RDATA;
                    end
                end else if (expire_s) begin
                    // Abort: complete the handshake with an all-ones data marker.
                    mem_rd_s  = 1'b0;
                    mem_wr_s  = 1'b0;
                    last_ld_s = owner_r;
                    state_s   = ST_DONE;
                    if (owner_r == OWNER_LD) begin
                        ld_ack_s   = 1'b1;
                        ld_rdata_s = {DATAWIDTH_DATA{1'b1}};
                    end else begin
                        cpu_ack_s   = 1'b1;
                        cpu_rdata_s = {DATAWIDTH_DATA{1'b1}};
                    end
                end else begin
                    state_s = ST_ACCESS;
                end
            end

            ST_DONE: begin
                if (!owner_req_s) begin
                    cpu_ack_s = 1'b0;
                    ld_ack_s  = 1'b0;
                    busy_s    = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end

            default: begin
                mem_rd_s  = 1'b0;
                mem_wr_s  = 1'b0;
                cpu_ack_s = 1'b0;
                ld_ack_s  = 1'b0;
                busy_s    = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase

        // A timeout in the same cycle as a clear request leaves ERR set.
        if (expire_s) begin
            err_s = 1'b1;
        end else if (err_clear_s) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // State and output registers; reset drops any strobe without waiting for memory.
    always_ff @(posedge Mem_Arbiter_CLOCK_50 or negedge Mem_Arbiter_RESET_InLow) begin
        if (!Mem_Arbiter_RESET_InLow) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWNER_CPU;
            we_r        <= 1'b0;
            last_ld_r   <= OWNER_LD;
            mem_addr_r  <= {DATAWIDTH_ADDR{1'b0}};
            mem_wdata_r <= {DATAWIDTH_DATA{1'b0}};
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            cpu_ack_r   <= 1'b0;
            ld_ack_r    <= 1'b0;
            cpu_rdata_r <= {DATAWIDTH_DATA{1'b0}};
            ld_rdata_r  <= {DATAWIDTH_DATA{1'b0}};
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            we_r        <= we_s;
            last_ld_r   <= last_ld_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_rd_r    <= mem_rd_s;
            mem_wr_r    <= mem_wr_s;
            cpu_ack_r   <= cpu_ack_s;
            ld_ack_r    <= ld_ack_s;
            cpu_rdata_r <= cpu_rdata_s;
            ld_rdata_r  <= ld_rdata_s;
            busy_r      <= busy_s;
            err_r       <= err_s;
        end
    end

    assign bus.Mem_Arbiter_CPU_RDATA = cpu_rdata_r;
    assign bus.Mem_Arbiter_CPU_ACK   = cpu_ack_r;
    assign bus.Mem_Arbiter_LD_RDATA  = ld_rdata_r;
    assign bus.Mem_Arbiter_LD_ACK    = ld_ack_r;
    assign bus.Mem_Arbiter_MEM_RD    = mem_rd_r;
    assign bus.Mem_Arbiter_MEM_WR    = mem_wr_r;
    assign bus.Mem_Arbiter_MEM_ADDR  = mem_addr_r;
    assign bus.Mem_Arbiter_MEM_WDATA = mem_wdata_r;
    assign bus.Mem_Arbiter_BUSY      = busy_r;
    assign bus.Mem_Arbiter_ERR       = err_r;

endmodule
